toggle_debounce: RTL and testbench

TOGGLE_DEBOUNCE -- requirements
Module: toggle_debounce

---
 rtl/toggle_debounce.sv | 66 ++++++
 tb/tb_toggle_debounce.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_debounce.sv
// toggle_debounce: synchronize and debounce a push-button, emitting a one-cycle T-flop enable per accepted edge.
module toggle_debounce #(
  parameter int DB_CYCLES = 4,
  parameter bit EDGE_SEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t,
  output logic       level,
  output logic [7:0] bounce_cnt
);
  typedef enum logic [1:0] {LOW_STABLE, RISE_CHK, HIGH_STABLE, FALL_CHK} state_t;
  localparam logic [15:0] LAST = 16'(DB_CYCLES - 1);
  state_t state;
  logic sync1, sync2;
  logic [15:0] cnt;
  logic [7:0] bounce_nxt;
  assign bounce_nxt = bounce_cnt + {7'd0, bounce_cnt != 8'hff};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= LOW_STABLE;
      cnt <= '0;
      t <= 1'b0;
      level <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      t <= 1'b0;
      case (state)
        LOW_STABLE: begin
          cnt <= {15'd0, sync2};
          if (sync2) state <= RISE_CHK;
        end
        RISE_CHK:
          if (!sync2) begin
            state <= LOW_STABLE;
            cnt <= '0;
            bounce_cnt <= bounce_nxt;
          end else if (cnt == LAST) begin
            state <= HIGH_STABLE;
            cnt <= '0;
            level <= 1'b1;
            t <= !EDGE_SEL;
          end else cnt <= cnt + 16'd1;
        HIGH_STABLE: begin
          cnt <= {15'd0, !sync2};
          if (!sync2) state <= FALL_CHK;
        end
        FALL_CHK:
          if (sync2) begin
            state <= HIGH_STABLE;
            cnt <= '0;
            bounce_cnt <= bounce_nxt;
          end else if (cnt == LAST) begin
            state <= LOW_STABLE;
            cnt <= '0;
            level <= 1'b0;
            t <= EDGE_SEL;
          end else cnt <= cnt + 16'd1;
      endcase
    end
endmodule

// File: tb/tb_toggle_debounce.sv
// tb_toggle_debounce: directed and randomized checks of toggle_debounce for both edge selections.
module tb_toggle_debounce;
  localparam int DB = 4;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0;
  logic t0, l0, t1, l1, q;
  logic [7:0] b0, b1;
  int n_cmp = 0, n_fail = 0;
  bit hist[$];
  bit samp[$];
  bit m_level, m_rise, m_fall;
  int m_bounce;

  toggle_debounce #(.DB_CYCLES(DB), .EDGE_SEL(1'b0)) u0 (.clk(clk), .rst(rst), .btn_in(btn), .t(t0), .level(l0), .bounce_cnt(b0));
  toggle_debounce #(.DB_CYCLES(DB), .EDGE_SEL(1'b1)) u1 (.clk(clk), .rst(rst), .btn_in(btn), .t(t1), .level(l1), .bounce_cnt(b1));

  always #5 clk = ~clk;

  // downstream T flip-flop fed by the press-edge pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else if (t0) q <= ~q;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a level flips once the last DB synchronized samples all disagree with it;
  // a sample agreeing with the level right after a disagreeing one is a rejected bounce.
  task automatic model_reset();
    hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
    samp.delete(); samp.push_back(1'b0);
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_bounce = 0;
  endtask

  task automatic model_step();
    bit s, prev, all_diff;
    s = hist[hist.size()-2];
    hist.push_back(btn);
    if (hist.size() > 4) void'(hist.pop_front());
    prev = samp[samp.size()-1];
    samp.push_back(s);
    if (samp.size() > 64) void'(samp.pop_front());
    all_diff = samp.size() >= DB;
    if (all_diff) for (int i = 0; i < DB; i++) if (samp[samp.size()-1-i] == m_level) all_diff = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0;
    if (all_diff) begin
      m_level = !m_level;
      m_rise = m_level;
      m_fall = !m_level;
    end else if (s == m_level && prev != m_level && m_bounce < 255) m_bounce++;
  endtask

  task automatic cycle(input bit v);
    btn = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    #2 rst = 1'b0;
    btn = v;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    btn = 1'b1;
    model_reset();
    #2;
    n_cmp++;
    if ({t0, l0, b0, t1, l1, b1} !== 20'd0) begin
      n_fail++; $display("FAIL reset_init: got %b want all zero", {t0, l0, b0, t1, l1, b1});
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_cmp++;
    if ({t0, l0, b0, t1, l1, b1} !== 20'd0) begin
      n_fail++; $display("FAIL reset_held: got %b want all zero", {t0, l0, b0, t1, l1, b1});
    end
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0);
  endtask

  task automatic test_clean_press();
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b1);
      n_cmp++;
      if (t0 !== (e == 6) || l0 !== (e >= 6) || b0 !== 8'd0 || t1 !== 1'b0) begin
        n_fail++; $display("FAIL clean_press e=%0d: got t=%b lvl=%b bc=%0d t1=%b want t=%b lvl=%b bc=0 t1=0", e, t0, l0, b0, t1, e == 6, e >= 6);
      end
    end
  endtask

  task automatic test_edge_sel();
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b0);
      n_cmp++;
      if (t1 !== (e == 6) || l1 !== (e < 6) || l0 !== (e < 6) || t0 !== 1'b0) begin
        n_fail++; $display("FAIL edge_sel_release e=%0d: got t1=%b lvl=%b t0=%b want t1=%b lvl=%b t0=0", e, t1, l1, t0, e == 6, e < 6);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    int pulses = 0;
    for (int e = 1; e <= 16; e++) begin
      cycle(e <= 8 ? pat[e-1] : 1'b1);
      pulses += int'(t0);
      n_cmp++;
      if (t0 !== (e == 9)) begin
        n_fail++; $display("FAIL bounce_pulse e=%0d: got t=%b want %b", e, t0, e == 9);
      end
    end
    n_cmp++;
    if (b0 !== 8'd1 || b1 !== 8'd1 || pulses != 1) begin
      n_fail++; $display("FAIL bounce_count: got bc=%0d/%0d pulses=%0d want bc=1/1 pulses=1", b0, b1, pulses);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({t0, l0, b0, t1, l1, b1} !== 20'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got %b want all zero", {t0, l0, b0, t1, l1, b1});
    end
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      cycle(1'b0);
      n_cmp++;
      if (t0 !== 1'b0 || l0 !== 1'b0 || b0 !== 8'd0 || t1 !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_after e=%0d: got t=%b lvl=%b bc=%0d t1=%b want 0 0 0 0", e, t0, l0, b0, t1);
      end
    end
  endtask

  task automatic test_press_at_release();
    do_reset(1'b1);
    for (int e = 1; e <= 12; e++) begin
      cycle(1'b1);
      n_cmp++;
      if (t0 !== (e == 6) || l0 !== (e >= 6)) begin
        n_fail++; $display("FAIL press_at_release e=%0d: got t=%b lvl=%b want t=%b lvl=%b", e, t0, l0, e == 6, e >= 6);
      end
    end
    for (int i = 0; i < 12; i++) cycle(1'b0);
  endtask

  task automatic test_random();
    int cyc = 0, last_t0 = -1000, last_t1 = -1000;
    bit v;
    while (cyc < 600) begin
      v = 1'($urandom_range(0, 1));
      for (int r = $urandom_range(1, 2 * DB); r > 0; r--) begin
        cycle(v);
        cyc++;
        n_cmp++;
        if ({t0, l0, t1, l1, b0, b1} !== {m_rise, m_level, m_fall, m_level, 8'(m_bounce), 8'(m_bounce)}) begin
          n_fail++; $display("FAIL random c=%0d: got t0=%b l=%b t1=%b l1=%b bc=%0d want t0=%b l=%b t1=%b bc=%0d", cyc, t0, l0, t1, l1, b0, m_rise, m_level, m_fall, m_bounce);
        end
        if (t0 === 1'b1) begin
          n_cmp++;
          if (cyc - last_t0 < 2 * DB) begin
            n_fail++; $display("FAIL pulse_gap t0: got %0d want >= %0d", cyc - last_t0, 2 * DB);
          end
          last_t0 = cyc;
        end
        if (t1 === 1'b1) begin
          n_cmp++;
          if (cyc - last_t1 < 2 * DB) begin
            n_fail++; $display("FAIL pulse_gap t1: got %0d want >= %0d", cyc - last_t1, 2 * DB);
          end
          last_t1 = cyc;
        end
      end
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    do_reset(1'b0);
    for (int g = 0; g < 300; g++) begin
      cycle(1'b1);
      bad += int'(t0 | t1 | l0);
      for (int i = 0; i < 8; i++) begin
        cycle(1'b0);
        bad += int'(t0 | t1 | l0);
      end
    end
    n_cmp++;
    if (b0 !== 8'd255 || b1 !== 8'd255 || 8'(m_bounce) !== 8'd255) begin
      n_fail++; $display("FAIL glitch_saturate: got bc=%0d/%0d want 255", b0, b1);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL glitch_quiet: got %0d cycles with t/level high want 0", bad);
    end
  endtask

  task automatic test_tff();
    bit exp_q = 1'b0;
    do_reset(1'b0);
    n_cmp++;
    if (q !== 1'b0) begin
      n_fail++; $display("FAIL tff_init: got q=%b want 0", q);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1);
      exp_q = !exp_q;
      for (int i = 0; i < 10; i++) cycle(1'b0);
      n_cmp++;
      if (q !== exp_q) begin
        n_fail++; $display("FAIL tff_press%0d: got q=%b want %b", p, q, exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_edge_sel();
    test_bounce();
    test_reset_mid();
    test_press_at_release();
    test_random();
    test_glitch();
    test_tff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
